fpu_req_arbiter: RTL and testbench

Shares one single-precision FPU datapath between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one operation in flight at a time.
- Holds operands stable for a per-opcode latency, captures the FPU result and returns it with a divide-by-zero flag.
- Sits between CPU-side issue logic and the FPU.

---
 rtl/fpu_req_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one single-precision FPU datapath between two
// requesters. Round-robin grant, one operation in flight, per-opcode latency,
// result returned on a per-requester valid/ready response channel together
// with a divide-by-zero flag.
//
// Optional feature macro: FPU_ARB_STATS_EN
//   defined   -> stat_ops0/stat_ops1 count completed ops (saturating)
//   undefined -> counters not built, stat ports tied to 0
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready           op request handshake (ready is combinational)
//   reqN_a/b/opcode            operands and opcode (00 ADD, 01 SUB, 10 DIV, 11 MUL)
//   rspN_valid/ready           result handshake
//   rspN_result/dz             result and divide-by-zero flag
//   fpu_a/b/opcode             registered operands to the FPU
//   fpu_result                 FPU result
//   busy                       op in flight
//   stat_ops0/1                completed-op counters
module fpu_req_arbiter #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [1:0]        req0_opcode,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [31:0]       rsp0_result,
  output logic              rsp0_dz,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic [1:0]        req1_opcode,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp1_result,
  output logic              rsp1_dz,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  output logic [1:0]        fpu_opcode,
  input  logic [31:0]       fpu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  stat_ops0,
  output logic [CNT_W-1:0]  stat_ops1
);

  // A latency of 0 is treated as 1
  localparam int unsigned ADD_L = (ADD_LAT == 0) ? 1 : ADD_LAT;
  localparam int unsigned MUL_L = (MUL_LAT == 0) ? 1 : MUL_LAT;
  localparam int unsigned DIV_L = (DIV_LAT == 0) ? 1 : DIV_LAT;
  localparam int unsigned MAX_AM = (ADD_L > MUL_L) ? ADD_L : MUL_L;
  localparam int unsigned MAX_L  = (MAX_AM > DIV_L) ? MAX_AM : DIV_L;
  localparam int unsigned LAT_W  = $clog2(MAX_L + 1);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t             r_state;
  logic               r_last;
  logic               r_owner;
  logic [LAT_W-1:0]   r_cnt;
  logic               r_dz;
  logic [31:0]        r_fpu_a;
  logic [31:0]        r_fpu_b;
  logic [1:0]         r_fpu_op;
  logic               r_rsp0_valid;
  logic [31:0]        r_rsp0_result;
  logic               r_rsp0_dz;
  logic               r_rsp1_valid;
  logic [31:0]        r_rsp1_result;
  logic               r_rsp1_dz;

  logic               w_idle;
  logic               w_elig0;
  logic               w_elig1;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_hs;
  logic               w_done;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic [1:0]         w_sel_op;
  logic               w_sel_dz;
  logic [LAT_W-1:0]   w_lat;

  // Eligibility uses the registered response valid, so a consume in cycle C
  // only makes the requester eligible from C+1.
  assign w_idle  = (r_state == S_IDLE);
  assign w_elig0 = req0_valid & ~r_rsp0_valid;
  assign w_elig1 = req1_valid & ~r_rsp1_valid;
  // On a tie the requester that was not served last wins
  assign w_gnt0  = w_idle & w_elig0 & (~w_elig1 | r_last);
  assign w_gnt1  = w_idle & w_elig1 & (~w_elig0 | ~r_last);
  assign w_hs    = w_gnt0 | w_gnt1;
  assign w_done  = (r_state == S_EXEC) && (r_cnt == '0);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign w_sel_a  = w_gnt1 ? req1_a      : req0_a;
  assign w_sel_b  = w_gnt1 ? req1_b      : req0_b;
  assign w_sel_op = w_gnt1 ? req1_opcode : req0_opcode;
  // Sign bit ignored so both +0 and -0 flag divide-by-zero
  assign w_sel_dz = (w_sel_op == 2'b10) && (w_sel_b[30:0] == 31'd0);

  // Per-opcode latency load value
  always_comb begin
    w_lat = LAT_W'(ADD_L);
    case (w_sel_op)
      2'b10:   w_lat = LAT_W'(DIV_L);
      2'b11:   w_lat = LAT_W'(MUL_L);
      default: w_lat = LAT_W'(ADD_L);
    endcase
  end

  // Arbitration FSM, operand latch and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_owner       <= 1'b0;
      r_cnt         <= '0;
      r_dz          <= 1'b0;
      r_fpu_a       <= '0;
      r_fpu_b       <= '0;
      r_fpu_op      <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_dz     <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_dz     <= 1'b0;
    end else begin
      if (r_rsp0_valid && rsp0_ready) r_rsp0_valid <= 1'b0;
      if (r_rsp1_valid && rsp1_ready) r_rsp1_valid <= 1'b0;

      if (r_state == S_IDLE) begin
        if (w_hs) begin
          r_fpu_a  <= w_sel_a;
          r_fpu_b  <= w_sel_b;
          r_fpu_op <= w_sel_op;
          r_owner  <= w_gnt1;
          r_last   <= w_gnt1;
          r_cnt    <= w_lat;
          r_dz     <= w_sel_dz;
          r_state  <= S_EXEC;
        end
      end else begin
        if (w_done) begin
          // Owner's response slot is known empty: it was required for grant
          if (r_owner) begin
            r_rsp1_valid  <= 1'b1;
            r_rsp1_result <= fpu_result;
            r_rsp1_dz     <= r_dz;
          end else begin
            r_rsp0_valid  <= 1'b1;
            r_rsp0_result <= fpu_result;
            r_rsp0_dz     <= r_dz;
          end
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt - LAT_W'(1);
        end
      end
    end
  end

  assign fpu_a       = r_fpu_a;
  assign fpu_b       = r_fpu_b;
  assign fpu_opcode  = r_fpu_op;
  assign busy        = (r_state == S_EXEC);
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_dz     = r_rsp0_dz;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_dz     = r_rsp1_dz;

`ifdef FPU_ARB_STATS_EN
  logic [CNT_W-1:0] r_stat0;
  logic [CNT_W-1:0] r_stat1;

  // Saturating completed-op counters, bumped when a response is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else begin
      if (w_done && !r_owner && !(&r_stat0)) r_stat0 <= r_stat0 + CNT_W'(1);
      if (w_done &&  r_owner && !(&r_stat1)) r_stat1 <= r_stat1 + CNT_W'(1);
    end
  end

  assign stat_ops0 = r_stat0;
  assign stat_ops1 = r_stat1;
`else
  assign stat_ops0 = '0;
  assign stat_ops1 = '0;
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed self-checking bench for fpu_req_arbiter with a one-edge FPU model.
module tb_fpu_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_dz;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic [1:0]  req0_opcode;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_dz;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic [1:0]  req1_opcode;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic [1:0]  fpu_opcode;
  logic        busy;
  logic [15:0] stat_ops0, stat_ops1;

  int n_total = 0;
  int n_pass  = 0;
  int gs[4];
  int gc[4];
  int ng;
  int bad;
  int g;
  bit seen;

  fpu_req_arbiter #(.ADD_LAT(1), .MUL_LAT(1), .DIV_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_opcode(req0_opcode),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_dz(rsp0_dz),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_opcode(req1_opcode),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_dz(rsp1_dz),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode),
    .fpu_result(fpu_result), .busy(busy),
    .stat_ops0(stat_ops0), .stat_ops1(stat_ops1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table-driven FPU: only the operand pairs used below are known
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (op == 2'b01 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (op == 2'b11 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == 2'b10 && b[30:0] == 31'd0) return {a[31] ^ b[31], 31'h7F800000};
    if (op == 2'b10 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) fpu_result <= fpu_model(fpu_a, fpu_b, fpu_opcode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic rdy(input int r);
    return (r == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rv(input int r);
    return (r == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  task automatic set_req(input int r, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic set_rsp_ready(input int r, input logic v);
    if (r == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  // Single op from idle: called and returns at posedge+1
  task automatic do_op(input int r, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_dz, input bit consume, input string tag);
    set_req(r, 1'b1, op, a, b);
    #1;
    chk({tag, ".ready"}, 32'(rdy(r)), 32'd1);
    @(posedge clk); #1;
    set_req(r, 1'b0, op, a, b);
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".fpu_a"}, fpu_a, a);
    chk({tag, ".fpu_b"}, fpu_b, b);
    chk({tag, ".fpu_op"}, 32'(fpu_opcode), 32'(op));
    @(posedge clk); #2;
    chk({tag, ".rsp_early"}, 32'(rv(r)), 32'd0);
    @(posedge clk); #2;
    chk({tag, ".rsp_valid"}, 32'(rv(r)), 32'd1);
    chk({tag, ".result"}, (r == 0) ? rsp0_result : rsp1_result, exp_res);
    chk({tag, ".dz"}, 32'((r == 0) ? rsp0_dz : rsp1_dz), 32'(exp_dz));
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    if (consume) begin
      set_rsp_ready(r, 1'b1);
      @(posedge clk); #1;
      set_rsp_ready(r, 1'b0);
      #1;
      chk({tag, ".consumed"}, 32'(rv(r)), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst.rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst.req0_ready", 32'(req0_ready), 32'd0);
    chk("rst.fpu_a", fpu_a, 32'd0);
    chk("rst.stat_ops0", 32'(stat_ops0), 32'd0);
    @(posedge clk); #1;

    // Directed arithmetic ops
    do_op(0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b1, "add0");
    do_op(1, 2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, "sub1");
    do_op(1, 2'b11, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b1, "mul1");
    do_op(0, 2'b10, 32'h40C00000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1, "div_pz");
    do_op(0, 2'b10, 32'h40C00000, 32'h80000000, 32'hFF800000, 1'b1, 1'b1, "div_nz");
    do_op(0, 2'b10, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1, "div_ok");
    #1;
    chk("hold.fpu_a", fpu_a, 32'h40C00000);
    chk("hold.fpu_b", fpu_b, 32'h40000000);
`ifdef FPU_ARB_STATS_EN
    chk("stat_ops0", 32'(stat_ops0), 32'd4);
    chk("stat_ops1", 32'(stat_ops1), 32'd2);
`else
    chk("stat_ops0", 32'(stat_ops0), 32'd0);
    chk("stat_ops1", 32'(stat_ops1), 32'd0);
`endif
    #1;

    // Tie with last=0: requester 1 wins, requester 0 follows when 1 completes
    set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000);
    set_req(1, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
    #1;
    chk("tie.req1_ready", 32'(req1_ready), 32'd1);
    chk("tie.req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    #1;
    chk("tie.req0_wait", 32'(req0_ready), 32'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("tie.rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("tie.rsp1_result", rsp1_result, 32'h40000000);
    chk("tie.req0_next", 32'(req0_ready), 32'd1);
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("tie.rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("tie.rsp0_result", rsp0_result, 32'h40400000);
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    @(posedge clk); #1;

    // Starvation: rsp0 unconsumed keeps requester 0 out
    rsp1_ready = 1'b1;
    do_op(0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, "starve_pre");
    set_req(0, 1'b1, 2'b01, 32'h40400000, 32'h3F800000);
    set_req(1, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
    bad = 0;
    g = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready) bad++;
      if (req1_ready) g++;
      if (!rsp0_valid || rsp0_result !== 32'h40400000) bad++;
      if (rsp1_valid && rsp1_result !== 32'h40000000) bad++;
      @(posedge clk); #1;
    end
    chk("starve.violations", 32'(bad), 32'd0);
    chk("starve.req1_grants", 32'(g), 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (rsp1_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("starve.rsp1_seen", 32'(seen), 32'd1);
    rsp0_ready = 1'b1;
    chk("starve.req0_blocked", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    #1;
    chk("starve.rsp0_cleared", 32'(rsp0_valid), 32'd0);
    chk("starve.req0_granted", 32'(req0_ready), 32'd1);
    chk("starve.req1_held", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("starve.rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("starve.rsp0_result", rsp0_result, 32'h40000000);
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    @(posedge clk); #1;

    // Reset in the first EXEC cycle drops the op
    set_req(1, 1'b1, 2'b11, 32'h40000000, 32'h40400000);
    #1;
    chk("rstx.req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    #1;
    chk("rstx.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstx.busy", 32'(busy), 32'd0);
    chk("rstx.rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rstx.rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rstx.fpu_a", fpu_a, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (rsp0_valid || rsp1_valid || busy) bad++;
    end
    chk("rstx.no_response", 32'(bad), 32'd0);
    @(posedge clk); #1;

    // Both requesting continuously with responses always taken
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000);
    set_req(1, 1'b1, 2'b01, 32'h40400000, 32'h3F800000);
    ng = 0;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (req0_ready && req1_ready) bad++;
      if (req0_ready || req1_ready) begin
        if (ng < 4) begin
          gs[ng] = req1_ready ? 1 : 0;
          gc[ng] = i;
        end
        ng++;
      end
      if (rsp0_valid && rsp0_result !== 32'h40400000) bad++;
      if (rsp1_valid && rsp1_result !== 32'h40000000) bad++;
      @(posedge clk); #1;
    end
    chk("alt.violations", 32'(bad), 32'd0);
    chk("alt.g0_who", 32'(gs[0]), 32'd0);
    chk("alt.g1_who", 32'(gs[1]), 32'd1);
    chk("alt.g2_who", 32'(gs[2]), 32'd0);
    chk("alt.g3_who", 32'(gs[3]), 32'd1);
    chk("alt.g0_cyc", 32'(gc[0]), 32'd0);
    chk("alt.g1_cyc", 32'(gc[1]), 32'd3);
    chk("alt.g2_cyc", 32'(gc[2]), 32'd6);
    chk("alt.g3_cyc", 32'(gc[3]), 32'd9);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("end.busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
